// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and types for the serial program loader.
//   FrameHeader        - first byte of every program frame
//   DefaultClksPerBit  - UART bit period in clk cycles (100 MHz / 115200)
//   AddrWidth          - instruction address width
//   InstrWidth         - instruction word width
//   state_e            - framing FSM states
//   rx_state_e         - UART byte receiver states
package imem_loader_pkg;

  localparam logic [7:0]  FrameHeader       = 8'hA5;
  localparam int unsigned DefaultClksPerBit = 868;
  localparam int unsigned AddrWidth         = 32;
  localparam int unsigned InstrWidth        = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    StRxIdle,
    StRxStart,
    StRxData,
    StRxStop
  } rx_state_e;

  // States in which a frame is being received.
  function automatic logic is_busy(state_e s);
    return s inside {StLenLo, StLenHi, StData, StCsum};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: board-side and instruction-memory-side signals of the loader.
//   load_en_i    - load mode enable (board switch)
//   rx_i         - UART RX line, idle high
//   imem_we_o    - one-cycle instruction-memory write strobe
//   imem_addr_o  - byte address of the word being written
//   imem_wdata_o - instruction word
//   cpu_hold_o   - holds the CPU in reset while high
//   busy_o       - frame reception in progress
//   done_o       - sticky: last frame loaded with a good checksum
//   err_o        - sticky: last frame failed
//   word_cnt_o   - words written in the current or last frame
// Modport master is the loader (drives the write port); slave is the board/memory side.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidth
) ();

  logic                  load_en_i;
  logic                  rx_i;
  logic                  imem_we_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [InstrWidth-1:0] imem_wdata_o;
  logic                  cpu_hold_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;
  logic [15:0]           word_cnt_o;

  modport master (
    input  load_en_i, rx_i,
    output imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, busy_o, done_o, err_o, word_cnt_o
  );

  modport slave (
    output load_en_i, rx_i,
    input  imem_we_o, imem_addr_o, imem_wdata_o, cpu_hold_o, busy_o, done_o, err_o, word_cnt_o
  );

endinterface

// File: rtl/imem_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver.
//   clk, reset  - system clock, synchronous active-high reset
//   rx          - asynchronous RX line, idle high
//   byte_data   - last received byte (valid with byte_valid)
//   byte_valid  - one-cycle pulse, byte received with a good stop bit
//   frame_err   - one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [15:0] HalfBit = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FullBit = 16'(CLKS_PER_BIT - 1);

  rx_state_e   state_q, state_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchronizer resets to idle-high so reset itself never looks like a start edge.
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StRxIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      StRxIdle: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = StRxStart;
      end
      StRxStart: begin
        if (cnt_q == HalfBit) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A glitch shorter than half a bit drops back to idle.
          state_d   = rx_sync_q ? StRxIdle : StRxData;
        end
      end
      StRxData: begin
        if (cnt_q == FullBit) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = StRxStop;
        end
      end
      StRxStop: begin
        if (cnt_q == FullBit) begin
          cnt_d   = '0;
          state_d = StRxIdle;
          valid_d = rx_sync_q;
          ferr_d  = !rx_sync_q;
        end
      end
      default: state_d = StRxIdle;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over UART and writes it into
// instruction memory, holding the CPU in reset while loading.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN*4 data bytes (little-endian words), CSUM (XOR of data).
//   clk, reset - system clock, synchronous active-high reset
//   bus        - imem_loader_if.master: load enable, RX line, write port and status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = DefaultClksPerBit,
  parameter int unsigned ADDR_WIDTH     = AddrWidth,
  parameter int unsigned MAX_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYCLES - 1);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx_i),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [7:0]            csum_q, csum_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [InstrWidth-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic [31:0]           tmo_cnt_q, tmo_cnt_d;
  logic [15:0]           len_new;
  logic                  busy;
  logic                  load_en;

  assign load_en = bus.load_en_i;
  assign busy    = is_busy(state_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      csum_q     <= csum_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    csum_d     = csum_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    tmo_cnt_d  = busy ? tmo_cnt_q + 32'd1 : '0;
    len_new    = {byte_data, len_q[7:0]};
    // Computed from the current state, so the hold follows a state change by one cycle.
    cpu_hold_d = load_en || !(state_q inside {StIdle, StDone});

    if (busy && !load_en) begin
      // Abort: sticky flags and memory contents are left as they are.
      state_d   = StIdle;
      tmo_cnt_d = '0;
    end else if (busy && tmo_cnt_q >= TmoLast) begin
      state_d = StErr;
      err_d   = 1'b1;
    end else if (busy && frame_err) begin
      state_d = StErr;
      err_d   = 1'b1;
    end else begin
      if (byte_valid) tmo_cnt_d = '0;
      case (state_q)
        StIdle: begin
          if (load_en && byte_valid && byte_data == FrameHeader) begin
            state_d    = StLenLo;
            done_d     = 1'b0;
            err_d      = 1'b0;
            word_cnt_d = '0;
            csum_d     = '0;
            byte_idx_d = '0;
          end
        end
        StLenLo: begin
          if (byte_valid) begin
            len_d[7:0] = byte_data;
            state_d    = StLenHi;
          end
        end
        StLenHi: begin
          if (byte_valid) begin
            len_d = len_new;
            if (32'(len_new) > MAX_WORDS) begin
              state_d = StErr;
              err_d   = 1'b1;
            end else if (len_new == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end
        StData: begin
          if (byte_valid) begin
            csum_d     = csum_q ^ byte_data;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_d[7:0]   = byte_data;
              2'd1: word_buf_d[15:8]  = byte_data;
              2'd2: word_buf_d[23:16] = byte_data;
              default: begin
                we_d       = 1'b1;
                addr_d     = ADDR_WIDTH'({word_cnt_q, 2'b00});
                wdata_d    = {byte_data, word_buf_q};
                word_cnt_d = word_cnt_q + 16'd1;
                if (word_cnt_q + 16'd1 == len_q) state_d = StCsum;
              end
            endcase
          end
        end
        StCsum: begin
          if (byte_valid) begin
            if (byte_data == csum_q) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StErr;
              err_d   = 1'b1;
            end
          end
        end
        StDone, StErr: begin
          if (!load_en) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.imem_we_o    = we_q;
  assign bus.imem_addr_o  = addr_q;
  assign bus.imem_wdata_o = wdata_q;
  assign bus.cpu_hold_o   = cpu_hold_q;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: UART frame stimulus with a write scoreboard.
module tb_imem_loader;

  localparam int unsigned Bit = 16;
  localparam int unsigned Tmo = 3000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  wr_t  exp_q[$];
  logic [31:0] exp_addr;
  logic [7:0]  exp_csum;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(32)) bus ();

  imem_loader #(
    .CLKS_PER_BIT  (Bit),
    .ADDR_WIDTH    (32),
    .MAX_WORDS     (1024),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Scoreboard: every write strobe is matched against the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we_o === 1'b1) begin
      vectors++;
      if (prev_we) begin
        miscompares++;
        $display("FAIL strobe_width: strobe high on consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: addr %h data %h, none expected",
                 bus.imem_addr_o, bus.imem_wdata_o);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        if (bus.imem_addr_o !== w.addr || bus.imem_wdata_o !== w.data) begin
          miscompares++;
          $display("FAIL write: got addr %h data %h, want addr %h data %h",
                   bus.imem_addr_o, bus.imem_wdata_o, w.addr, w.data);
        end
      end
    end
    prev_we = bus.imem_we_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.rx_i = 1'b0;
    repeat (Bit) tick();
    for (int i = 0; i < 8; i++) begin
      bus.rx_i = b[i];
      repeat (Bit) tick();
    end
    bus.rx_i = stop_bit;
    repeat (Bit) tick();
    bus.rx_i = 1'b1;
    repeat (2 * Bit) tick();
  endtask

  task automatic begin_frame(input logic [15:0] len);
    exp_addr = '0;
    exp_csum = '0;
    send_byte(8'hA5, 1'b1);
    send_byte(len[7:0], 1'b1);
    send_byte(len[15:8], 1'b1);
  endtask

  task automatic send_data_byte(input logic [7:0] b);
    exp_csum = exp_csum ^ b;
    send_byte(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_q.push_back('{addr: exp_addr, data: w});
    exp_addr = exp_addr + 32'd4;
    for (int k = 0; k < 4; k++) send_data_byte(w[8*k +: 8]);
  endtask

  task automatic release_load();
    bus.load_en_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    bus.load_en_i = 1'b0;
    bus.rx_i = 1'b1;
    reset = 1'b1;
    repeat (5) tick();
    vectors++;
    if ({bus.imem_we_o, bus.cpu_hold_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 ||
        bus.word_cnt_o !== 16'd0 || bus.imem_addr_o !== 32'd0 || bus.imem_wdata_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: we/hold/busy/done/err=%b cnt=%h, want all 0",
               {bus.imem_we_o, bus.cpu_hold_o, bus.busy_o, bus.done_o, bus.err_o}, bus.word_cnt_o);
    end
    reset = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus.cpu_hold_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_idle: got %b want 0", bus.cpu_hold_o);
    end
  endtask

  task automatic test_good_frame();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_word(32'h0010_0013);
    send_word(32'h0020_0093);
    send_byte(exp_csum, 1'b1);
    repeat (4) tick();
    vectors++;
    if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL good_status: done=%b err=%b, want 1 0", bus.done_o, bus.err_o);
    end
    vectors++;
    if (bus.word_cnt_o !== 16'd2) begin
      miscompares++;
      $display("FAIL good_word_cnt: got %0d want 2", bus.word_cnt_o);
    end
    vectors++;
    if (bus.cpu_hold_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL good_hold_busy: hold=%b busy=%b, want 1 0", bus.cpu_hold_o, bus.busy_o);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL good_strobes: %0d writes missing, want 0", exp_q.size());
    end
    release_load();
    vectors++;
    if (bus.cpu_hold_o !== 1'b0 || bus.done_o !== 1'b1) begin
      miscompares++;
      $display("FAIL good_release: hold=%b done=%b, want 0 1", bus.cpu_hold_o, bus.done_o);
    end
  endtask

  task automatic test_bad_csum();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_word(32'h0010_0013);
    send_word(32'h0020_0093);
    send_byte(8'h00, 1'b1);
    repeat (4) tick();
    vectors++;
    if (bus.err_o !== 1'b1 || bus.done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL csum_status: err=%b done=%b, want 1 0", bus.err_o, bus.done_o);
    end
    vectors++;
    if (bus.cpu_hold_o !== 1'b1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL csum_hold_strobes: hold=%b missing=%0d, want 1 0", bus.cpu_hold_o, exp_q.size());
    end
    release_load();
    vectors++;
    if (bus.cpu_hold_o !== 1'b0 || bus.err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL csum_release: hold=%b err=%b, want 0 1", bus.cpu_hold_o, bus.err_o);
    end
  endtask

  task automatic test_ignore_bytes();
    bus.load_en_i = 1'b1;
    send_byte(8'h5A, 1'b1);
    send_byte(8'h11, 1'b1);
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ignore_idle: busy=%b err=%b, want 0 1", bus.busy_o, bus.err_o);
    end
    begin_frame(16'd0);
    send_byte(exp_csum, 1'b1);
    repeat (4) tick();
    vectors++;
    if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0 || bus.word_cnt_o !== 16'd0) begin
      miscompares++;
      $display("FAIL empty_frame: done=%b err=%b cnt=%0d, want 1 0 0",
               bus.done_o, bus.err_o, bus.word_cnt_o);
    end
    release_load();
  endtask

  task automatic test_len_and_timeout();
    bus.load_en_i = 1'b1;
    begin_frame(16'd1025);
    repeat (4) tick();
    vectors++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.cpu_hold_o !== 1'b1) begin
      miscompares++;
      $display("FAIL len_too_big: err=%b busy=%b hold=%b, want 1 0 1",
               bus.err_o, bus.busy_o, bus.cpu_hold_o);
    end
    release_load();
    bus.load_en_i = 1'b1;
    begin_frame(16'd1);
    send_data_byte(8'h13);
    send_data_byte(8'h00);
    repeat (1000) tick();
    vectors++;
    if (bus.busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: busy=%b err=%b, want 1 0", bus.busy_o, bus.err_o);
    end
    repeat (2100) tick();
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: busy=%b err=%b, want 0 1", bus.busy_o, bus.err_o);
    end
    release_load();
  endtask

  task automatic test_frame_err();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_word(32'h0010_0013);
    send_byte(8'h55, 1'b0);
    repeat (4) tick();
    vectors++;
    if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_err: err=%b busy=%b missing=%0d, want 1 0 0",
               bus.err_o, bus.busy_o, exp_q.size());
    end
    release_load();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_word(32'hDEAD_BEEF);
    send_word(32'h1234_5678);
    send_byte(exp_csum, 1'b1);
    repeat (4) tick();
    vectors++;
    if (bus.done_o !== 1'b1 || bus.err_o !== 1'b0 || bus.word_cnt_o !== 16'd2) begin
      miscompares++;
      $display("FAIL reload: done=%b err=%b cnt=%0d, want 1 0 2",
               bus.done_o, bus.err_o, bus.word_cnt_o);
    end
    release_load();
  endtask

  task automatic test_abort();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_word(32'h0010_0013);
    send_data_byte(8'h93);
    bus.load_en_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.busy_o !== 1'b0 || bus.cpu_hold_o !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b hold=%b, want 0 1", bus.busy_o, bus.cpu_hold_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.cpu_hold_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_hold: got %b want 0", bus.cpu_hold_o);
    end
    repeat (4 * Bit) tick();
    vectors++;
    if (bus.done_o !== 1'b0 || bus.err_o !== 1'b0 || bus.word_cnt_o !== 16'd1 ||
        exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_state: done=%b err=%b cnt=%0d missing=%0d, want 0 0 1 0",
               bus.done_o, bus.err_o, bus.word_cnt_o, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.load_en_i = 1'b1;
    begin_frame(16'd2);
    send_data_byte(8'h13);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.imem_we_o, bus.cpu_hold_o, bus.busy_o, bus.done_o, bus.err_o} !== 5'b0 ||
        bus.word_cnt_o !== 16'd0 || bus.imem_wdata_o !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset: we/hold/busy/done/err=%b cnt=%0d wdata=%h, want all 0",
               {bus.imem_we_o, bus.cpu_hold_o, bus.busy_o, bus.done_o, bus.err_o},
               bus.word_cnt_o, bus.imem_wdata_o);
    end
    tick();
    reset = 1'b0;
    repeat (2) tick();
    begin_frame(16'd1);
    send_word(32'h0000_006F);
    send_byte(exp_csum, 1'b1);
    repeat (4) tick();
    vectors++;
    if (bus.done_o !== 1'b1 || bus.word_cnt_o !== 16'd1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset: done=%b cnt=%0d missing=%0d, want 1 1 0",
               bus.done_o, bus.word_cnt_o, exp_q.size());
    end
    release_load();
  endtask

  initial begin
    bus.load_en_i = 1'b0;
    bus.rx_i = 1'b1;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_ignore_bytes();
    test_len_and_timeout();
    test_frame_err();
    test_abort();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
